fetch_aligner: RTL and testbench

Instruction-fetch aligner for the RV32IC 5-stage pipeline. It sits in the IF stage between the instruction memory and the IF/ID register. It fetches 32-bit words from word-aligned addresses and splits or joins 16-bit halfwords into whole instructions. For each instruction it presents the raw bits, the instruction's PC and `c_inst_flag` to the decompressor and to the decode controller. `c_inst_flag` selects PC+2 vs PC+4 sequencing downstream.

---
 rtl/fetch_aligner.sv | 197 +++++++++++++++++++
 tb/tb_fetch_aligner.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_aligner.sv
// fetch_aligner: IF-stage aligner turning word fetches into whole RV32 instructions for decode.
// Define FETCH_RVC_EN for compressed (16-bit) support; without it every fetched word is one 32-bit instruction.
module fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        c_inst_flag,
    output logic        instr_valid
);
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] resp_addr_q, resp_addr_d;
    logic [1:0]  inflight_q, inflight_d;
    logic [1:0]  discard_q, discard_d;
    logic [1:0]  fifo_count_q, fifo_count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [31:0] fifo_data_q [2];
    logic [31:0] fifo_addr_q [2];
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        c_inst_flag_q, c_inst_flag_d;
    logic        instr_valid_q, instr_valid_d;
`ifdef FETCH_RVC_EN
    logic [15:0] hbuf_q, hbuf_d;
    logic [31:0] hpc_q, hpc_d;
    logic        hvalid_q, hvalid_d;
    logic        skip_low_q, skip_low_d;
`endif
    logic        resp_ok, live, head_avail, load, pop, fifo_pop, push;
    logic [31:0] head_data, head_addr;
    logic [2:0]  occupancy;
    logic        unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];

    always_comb begin
        // Memory latency is exactly one cycle, so the responding word's address is the last request's.
        resp_ok    = imem_rvalid && (inflight_q != 2'd0);
        live       = resp_ok && (discard_q == 2'd0) && !redirect;
        head_avail = (fifo_count_q != 2'd0) || live;
        head_data  = (fifo_count_q != 2'd0) ? fifo_data_q[rd_ptr_q] : imem_rdata;
        head_addr  = (fifo_count_q != 2'd0) ? fifo_addr_q[rd_ptr_q] : resp_addr_q;
        load       = !instr_valid_q || !stall;

        pop           = 1'b0;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        c_inst_flag_d = c_inst_flag_q;
        instr_valid_d = instr_valid_q;
`ifdef FETCH_RVC_EN
        hbuf_d     = hbuf_q;
        hpc_d      = hpc_q;
        hvalid_d   = hvalid_q;
        skip_low_d = skip_low_q;
`endif

        if (load) begin
            instr_valid_d = 1'b0;
`ifdef FETCH_RVC_EN
            if (hvalid_q && (hbuf_q[1:0] != 2'b11)) begin
                instr_d       = {16'h0, hbuf_q};
                instr_pc_d    = hpc_q;
                c_inst_flag_d = 1'b1;
                instr_valid_d = 1'b1;
                hvalid_d      = 1'b0;
            end else if (hvalid_q && head_avail) begin
                instr_d       = {head_data[15:0], hbuf_q};
                instr_pc_d    = hpc_q;
                c_inst_flag_d = 1'b0;
                instr_valid_d = 1'b1;
                pop           = 1'b1;
                hbuf_d        = head_data[31:16];
                hpc_d         = head_addr + 32'd2;
            end else if (!hvalid_q && head_avail && skip_low_q) begin
                pop        = 1'b1;
                hbuf_d     = head_data[31:16];
                hvalid_d   = 1'b1;
                hpc_d      = head_addr + 32'd2;
                skip_low_d = 1'b0;
            end else if (!hvalid_q && head_avail && (head_data[1:0] != 2'b11)) begin
                instr_d       = {16'h0, head_data[15:0]};
                instr_pc_d    = head_addr;
                c_inst_flag_d = 1'b1;
                instr_valid_d = 1'b1;
                pop           = 1'b1;
                hbuf_d        = head_data[31:16];
                hvalid_d      = 1'b1;
                hpc_d         = head_addr + 32'd2;
            end else if (!hvalid_q && head_avail) begin
                instr_d       = head_data;
                instr_pc_d    = head_addr;
                c_inst_flag_d = 1'b0;
                instr_valid_d = 1'b1;
                pop           = 1'b1;
            end
`else
            if (head_avail) begin
                instr_d       = head_data;
                instr_pc_d    = head_addr;
                c_inst_flag_d = 1'b0;
                instr_valid_d = 1'b1;
                pop           = 1'b1;
            end
`endif
        end

        // A pop with an empty FIFO consumes the arriving word directly instead of storing it.
        fifo_pop     = pop && (fifo_count_q != 2'd0);
        push         = live && !(pop && (fifo_count_q == 2'd0));
        fifo_count_d = fifo_count_q + {1'b0, push} - {1'b0, fifo_pop};
        rd_ptr_d     = rd_ptr_q ^ fifo_pop;
        wr_ptr_d     = wr_ptr_q ^ push;

        occupancy   = {1'b0, fifo_count_q} + {1'b0, inflight_q} - {2'b00, pop};
        imem_req    = !rst && !redirect && (occupancy < 3'd2);
        imem_addr   = fetch_pc_q;
        fetch_pc_d  = imem_req ? (fetch_pc_q + 32'd4) : fetch_pc_q;
        resp_addr_d = imem_req ? fetch_pc_q : resp_addr_q;
        inflight_d  = inflight_q + {1'b0, imem_req} - {1'b0, resp_ok};
        discard_d   = (resp_ok && (discard_q != 2'd0)) ? (discard_q - 2'd1) : discard_q;

        if (redirect) begin
            fifo_count_d  = 2'd0;
            rd_ptr_d      = 1'b0;
            wr_ptr_d      = 1'b0;
            instr_valid_d = 1'b0;
            discard_d     = inflight_q - {1'b0, resp_ok};
            fetch_pc_d    = {redirect_pc[31:2], 2'b00};
`ifdef FETCH_RVC_EN
            hvalid_d   = 1'b0;
            skip_low_d = redirect_pc[1];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= {RESET_PC[31:2], 2'b00};
            resp_addr_q   <= 32'h0;
            inflight_q    <= 2'd0;
            discard_q     <= 2'd0;
            fifo_count_q  <= 2'd0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            instr_q       <= 32'h0;
            instr_pc_q    <= 32'h0;
            c_inst_flag_q <= 1'b0;
            instr_valid_q <= 1'b0;
`ifdef FETCH_RVC_EN
            hbuf_q     <= 16'h0;
            hpc_q      <= 32'h0;
            hvalid_q   <= 1'b0;
            skip_low_q <= RESET_PC[1];
`endif
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_addr_q   <= resp_addr_d;
            inflight_q    <= inflight_d;
            discard_q     <= discard_d;
            fifo_count_q  <= fifo_count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            c_inst_flag_q <= c_inst_flag_d;
            instr_valid_q <= instr_valid_d;
`ifdef FETCH_RVC_EN
            hbuf_q     <= hbuf_d;
            hpc_q      <= hpc_d;
            hvalid_q   <= hvalid_d;
            skip_low_q <= skip_low_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= imem_rdata;
            fifo_addr_q[wr_ptr_q] <= resp_addr_q;
        end
    end

    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign c_inst_flag = c_inst_flag_q;
    assign instr_valid = instr_valid_q;
endmodule

// File: tb/tb_fetch_aligner.sv
// Directed bench for fetch_aligner: vector table of fetch scenarios plus reset, stall and reset-mid-fetch sequences.
module tb_fetch_aligner;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        c_inst_flag;
    logic        instr_valid;

    int passed = 0;
    int total  = 0;

    logic [31:0] mem [128];

    typedef struct {
        logic [31:0]      start;
        logic [31:0]      w0, w1, w2;
        int               n;
        logic [3:0][31:0] ei;
        logic [3:0][31:0] ep;
        logic [3:0]       ec;
    } vec_t;

    vec_t vecs [6];

    fetch_aligner #(.RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
        .instr(instr), .instr_pc(instr_pc), .c_inst_flag(c_inst_flag), .instr_valid(instr_valid)
    );

    always #5 clk = ~clk;

    // Single-cycle instruction memory.
    always @(posedge clk) begin
        imem_rvalid <= imem_req;
        imem_rdata  <= mem[imem_addr[8:2]];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        total++;
        if (act === req_v) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, req_v);
    endtask

    function automatic vec_t mk(input logic [31:0] start, w0, w1, w2, input int n,
                                input logic [3:0][31:0] ei, ep, input logic [3:0] ec);
        vec_t t;
        t.start = start; t.w0 = w0; t.w1 = w1; t.w2 = w2;
        t.n = n; t.ei = ei; t.ep = ep; t.ec = ec;
        return t;
    endfunction

    task automatic fill_mem();
        for (int k = 0; k < 128; k++) mem[k] = (32'(k) << 20) | 32'h13;
    endtask

    task automatic expect_stream(input string tag, input int n, input logic [3:0][31:0] ei,
                                 input logic [3:0][31:0] ep, input logic [3:0] ec);
        int got, cyc, last;
        got = 0; cyc = 0; last = 0;
        while (got < n && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (instr_valid) begin
                check({tag, " instr"}, instr, ei[got]);
                check({tag, " pc"}, instr_pc, ep[got]);
                check({tag, " c_flag"}, {31'b0, c_inst_flag}, {31'b0, ec[got]});
                if (got > 0) check({tag, " gap"}, 32'(cyc - last), 32'd1);
                last = cyc;
                got++;
            end
            $display("%s cycle %0d: valid=%0b instr=%h pc=%h c=%0b", tag, cyc, instr_valid, instr, instr_pc, c_inst_flag);
        end
        check({tag, " count"}, 32'(got), 32'(n));
    endtask

    initial begin
        vec_t t;
        int   idx, lat;
        logic [31:0] held_i, held_p;
        logic [31:0] rs_i [2];
        logic [31:0] rs_p [2];
        logic        rs_c [2];

`ifdef FETCH_RVC_EN
        vecs[0] = mk(32'h0,   32'h00A00093, 32'h00100113, 32'h00000013, 3,
                     {32'h0, 32'h13, 32'h00100113, 32'h00A00093}, {32'h0, 32'h8, 32'h4, 32'h0}, 4'b0000);
        vecs[1] = mk(32'h0,   32'h45054501, 32'h00000013, 32'h00300013, 3,
                     {32'h0, 32'h13, 32'h4505, 32'h4501}, {32'h0, 32'h4, 32'h2, 32'h0}, 4'b0011);
        vecs[2] = mk(32'h0,   32'h00934501, 32'h450500A0, 32'h00000013, 4,
                     {32'h13, 32'h4505, 32'h00A00093, 32'h4501}, {32'h8, 32'h6, 32'h2, 32'h0}, 4'b0101);
        vecs[3] = mk(32'h102, 32'h45094501, 32'h00100113, 32'h00000013, 3,
                     {32'h0, 32'h13, 32'h00100113, 32'h4509}, {32'h0, 32'h108, 32'h104, 32'h102}, 4'b0001);
        vecs[4] = mk(32'h102, 32'h02934501, 32'h44110050, 32'h00000013, 3,
                     {32'h0, 32'h13, 32'h4411, 32'h00500293}, {32'h0, 32'h108, 32'h106, 32'h102}, 4'b0010);
        vecs[5] = mk(32'h8,   32'h00010001, 32'h00A00093, 32'h00000013, 3,
                     {32'h0, 32'h00A00093, 32'h1, 32'h1}, {32'h0, 32'hC, 32'hA, 32'h8}, 4'b0011);
        rs_i[0] = 32'h4501;     rs_p[0] = 32'h0; rs_c[0] = 1'b1;
        rs_i[1] = 32'h00A00093; rs_p[1] = 32'h2; rs_c[1] = 1'b0;
`else
        vecs[0] = mk(32'h0,   32'h00A00093, 32'h00100113, 32'h00000013, 3,
                     {32'h0, 32'h13, 32'h00100113, 32'h00A00093}, {32'h0, 32'h8, 32'h4, 32'h0}, 4'b0000);
        vecs[1] = mk(32'h0,   32'h45054501, 32'h00000013, 32'h00300013, 3,
                     {32'h0, 32'h00300013, 32'h13, 32'h45054501}, {32'h0, 32'h8, 32'h4, 32'h0}, 4'b0000);
        vecs[2] = mk(32'h0,   32'h00934501, 32'h450500A0, 32'h00000013, 4,
                     {32'h00300013, 32'h13, 32'h450500A0, 32'h00934501}, {32'hC, 32'h8, 32'h4, 32'h0}, 4'b0000);
        vecs[3] = mk(32'h102, 32'h45094501, 32'h00100113, 32'h00000013, 3,
                     {32'h0, 32'h13, 32'h00100113, 32'h45094501}, {32'h0, 32'h108, 32'h104, 32'h100}, 4'b0000);
        vecs[4] = mk(32'h102, 32'h02934501, 32'h44110050, 32'h00000013, 3,
                     {32'h0, 32'h13, 32'h44110050, 32'h02934501}, {32'h0, 32'h108, 32'h104, 32'h100}, 4'b0000);
        vecs[5] = mk(32'h8,   32'h00010001, 32'h00A00093, 32'h00000013, 3,
                     {32'h0, 32'h13, 32'h00A00093, 32'h00010001}, {32'h0, 32'h10, 32'hC, 32'h8}, 4'b0000);
        rs_i[0] = 32'h00934501; rs_p[0] = 32'h0; rs_c[0] = 1'b0;
        rs_i[1] = 32'h450500A0; rs_p[1] = 32'h4; rs_c[1] = 1'b0;
`endif

        // Reset state, first request, latency and stall hold.
        fill_mem();
        @(negedge clk);
        check("reset instr_valid", {31'b0, instr_valid}, 32'd0);
        check("reset instr", instr, 32'h0);
        check("reset instr_pc", instr_pc, 32'h0);
        check("reset c_flag", {31'b0, c_inst_flag}, 32'd0);
        check("reset imem_req", {31'b0, imem_req}, 32'd0);
        rst = 1'b0;
        #1;
        check("first imem_req", {31'b0, imem_req}, 32'd1);
        check("first imem_addr", imem_addr, 32'h0);
        lat = 0;
        while (!instr_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("fetch latency", 32'(lat), 32'd2);
        check("first instr", instr, 32'h00000013);
        check("first pc", instr_pc, 32'h0);
        $display("latency test: cycles=%0d instr=%h pc=%h", lat, instr, instr_pc);
        held_i = instr;
        held_p = instr_pc;
        stall = 1'b1;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            check("stall instr", instr, 32'h00000013);
            check("stall pc", instr_pc, 32'h0);
            check("stall valid", {31'b0, instr_valid}, 32'd1);
            $display("stall cycle %0d: instr=%h pc=%h held=%h/%h req=%0b", s, instr, instr_pc, held_i, held_p, imem_req);
        end
        check("stall imem_req off", {31'b0, imem_req}, 32'd0);
        stall = 1'b0;
        expect_stream("post-stall", 4, {32'h00400013, 32'h00300013, 32'h00200013, 32'h00100013},
                      {32'h10, 32'hC, 32'h8, 32'h4}, 4'b0000);

        // Vector table.
        for (int v = 0; v < 6; v++) begin
            t = vecs[v];
            rst = 1'b1;
            stall = 1'b0;
            redirect = 1'b0;
            fill_mem();
            idx = int'(t.start[8:2]);
            mem[idx]     = t.w0;
            mem[idx + 1] = t.w1;
            mem[idx + 2] = t.w2;
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
            if (t.start != 32'h0) begin
                @(negedge clk);
                redirect    = 1'b1;
                redirect_pc = t.start;
                @(negedge clk);
                redirect = 1'b0;
                #1;
                check($sformatf("vec%0d flush valid", v), {31'b0, instr_valid}, 32'd0);
                check($sformatf("vec%0d refetch req", v), {31'b0, imem_req}, 32'd1);
                check($sformatf("vec%0d refetch addr", v), imem_addr, {t.start[31:2], 2'b00});
            end
            expect_stream($sformatf("vec%0d", v), t.n, t.ei, t.ep, t.ec);
        end

        // Reset pulse during a straddling fetch while a response is still arriving.
        rst = 1'b1;
        fill_mem();
        mem[0] = 32'h00934501;
        mem[1] = 32'h450500A0;
        @(negedge clk);
        rst = 1'b0;
        lat = 0;
        while (!instr_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("pre-reset output seen", {31'b0, instr_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check("async reset valid", {31'b0, instr_valid}, 32'd0);
        check("async reset req", {31'b0, imem_req}, 32'd0);
        #1;
        rst = 1'b0;
        expect_stream("restart", 2, {32'h0, 32'h0, rs_i[1], rs_i[0]},
                      {32'h0, 32'h0, rs_p[1], rs_p[0]}, {2'b00, rs_c[1], rs_c[0]});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
